rng_arbiter: RTL
================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the random source (2..8).
REQ-002 Parameter LFSR_W, fixed 16: width of the random value.
REQ-003 Port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port `req`, input, N_REQ bits: per-requester request; held high until acknowledged.
REQ-006 Port `ack`, input, N_REQ bits: per-requester consume strobe; only the granted bit is honoured.
REQ-007 Port `grant`, output, N_REQ bits: one-hot grant, or all-zero.
REQ-008 Port `rnd_valid`, output, 1 bit: rnd_data is valid for the granted requester.
REQ-009 Port `rnd_data`, output, 16 bits: current LFSR value.
REQ-010 Port `seed_we`, input, 1 bit: seed load strobe.
REQ-011 Port `seed_data`, input, 16 bits: seed value.

Function
REQ-012 The LFSR SHALL be a 16-bit Fibonacci LFSR: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, giving a maximal period of 65535.
REQ-013 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-014 IDLE: grant=0 and rnd_valid=0; if any req bit is high, the FSM SHALL select a winner round-robin, starting at pointer `ptr` and searching upward with wrap, latch the winner, and enter GRANT the next cycle.
REQ-015 GRANT: grant=one-hot winner and rnd_valid=1; rnd_data SHALL be held stable for the whole GRANT state.
REQ-016 GRANT with ack[winner]=1: the LFSR SHALL step once, ptr SHALL become (winner+1) mod N_REQ, and the FSM SHALL return to IDLE. Grant-to-grant spacing is therefore at least 2 cycles.
REQ-017 GRANT with req[winner]=0 and no ack (abort): the FSM SHALL return to IDLE, the LFSR SHALL NOT step, and ptr SHALL be unchanged.
REQ-018 ack bits of non-granted requesters SHALL be ignored.
REQ-019 ack and req dropping in the same cycle SHALL be treated as a completed ack (REQ-016).
REQ-020 The LFSR SHALL step only on an ack; it SHALL never free-run.
REQ-021 A zero value from any source SHALL be replaced by 16'h0001 so the LFSR can never lock up.
REQ-022 rnd_data SHALL be driven directly from the LFSR register (no combinational path from req or ack).

Reset
REQ-023 While rst=1: state=IDLE, lfsr=16'h0001, ptr=0, seed_pending=0, grant=0, rnd_valid=0.
REQ-024 rst asserted in GRANT SHALL drop grant and rnd_valid asynchronously, with no LFSR step.
REQ-025 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-026 The macro RNG_RESEED_EN SHALL control seed loading.
REQ-027 With RNG_RESEED_EN defined, seed_we in IDLE SHALL load seed_data into the LFSR on that edge.
REQ-028 With RNG_RESEED_EN defined, seed_we in GRANT SHALL latch seed_data into a pending register.
REQ-029 The pending seed SHALL be applied on the edge that leaves GRANT, overriding the step; a later seed_we SHALL overwrite the pending value.
REQ-030 Without RNG_RESEED_EN, seed_we and seed_data SHALL be ignored and no pending register SHALL exist.

Verification
REQ-031 Scenario: reset release, req=4'b0001, ack on the first GRANT cycle -> grant=0001, rnd_data=0x0001, then lfsr=0x0002.
REQ-032 Scenario: req=4'b1111 held, each grant acked immediately -> grants 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
REQ-033 Scenario: granted requester drops req without ack -> IDLE, lfsr unchanged; the same requester is regranted on its next request.
REQ-034 Scenario: ack on requester 2 while requester 0 is granted -> no effect; grant held and rnd_data stable.
REQ-035 Scenario (RNG_RESEED_EN): seed_we with 0xACE1 in GRANT, then ack -> lfsr=0xACE1 in IDLE; seed 0x0000 loaded in IDLE -> lfsr=0x0001.
REQ-036 Scenario: rst pulsed mid-GRANT -> grant=0 immediately, lfsr=0x0001, ptr=0.

Source files
------------

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter that hands out values from a shared
// 16-bit Fibonacci LFSR to N_REQ requesters, one grant at a time.
// The LFSR steps only when the granted requester acknowledges consumption.
// Optional build macro RNG_RESEED_EN enables run-time seed loading, including
// deferred seeds captured during GRANT. Without it, seed_we and seed_data
// are ignored.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate round-robin from ptr when any req is high
// GRANT | one-hot grant to latched winner; rnd_data held stable
module rng_arbiter #(
   parameter int N_REQ  = 4,
   parameter int LFSR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   input  logic [N_REQ-1:0]  ack,
   output logic [N_REQ-1:0]  grant,
   output logic              rnd_valid,
   output logic [LFSR_W-1:0] rnd_data,
   input  logic              seed_we,
   input  logic [LFSR_W-1:0] seed_data
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state;
   logic [LFSR_W-1:0] lfsr;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] winner;
   // Set on the first edge after reset; holds off arbitration one cycle so
   // the first grant lands no earlier than the second edge.
   logic             ready;

   logic             found;
   logic [PTR_W-1:0] win_nxt;
   logic [N_REQ-1:0] win_onehot;
   logic [PTR_W-1:0] ptr_inc;
   logic             ack_win;
   logic             req_win;
   int               idx;

`ifdef RNG_RESEED_EN
   logic              seed_pending;
   logic [LFSR_W-1:0] seed_pend_val;
`else
   wire unused_seed = ^{seed_we, seed_data};
`endif

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // All-zero is the LFSR lock-up state; substitute 1 on any load.
   function automatic logic [LFSR_W-1:0] nonzero(input logic [LFSR_W-1:0] v);
      return (v == '0) ? LFSR_W'(1) : v;
   endfunction

   // Round-robin search starting at ptr, wrapping at N_REQ.
   always_comb begin
      found      = 1'b0;
      win_nxt    = '0;
      win_onehot = '0;
      idx        = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            win_nxt = PTR_W'(idx);
         end
      end
      win_onehot[win_nxt] = 1'b1;
   end

   // Winner-relative strobes; ack bits of other requesters never reach here.
   always_comb begin
      ack_win = ack[winner];
      req_win = req[winner];
      ptr_inc = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
   end

   assign rnd_data = lfsr;

   // Arbiter FSM with registered grant/rnd_valid and the LFSR/seed state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= LFSR_W'(1);
         ptr       <= '0;
         winner    <= '0;
         grant     <= '0;
         rnd_valid <= 1'b0;
         ready     <= 1'b0;
`ifdef RNG_RESEED_EN
         seed_pending  <= 1'b0;
         seed_pend_val <= '0;
`endif
      end else begin
         ready <= 1'b1;
         case (state)
            IDLE: begin
`ifdef RNG_RESEED_EN
               if (seed_we) lfsr <= nonzero(seed_data);
`endif
               if (ready && found) begin
                  winner    <= win_nxt;
                  grant     <= win_onehot;
                  rnd_valid <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               // Ack wins over a simultaneous req drop; req drop alone aborts.
               if (ack_win || !req_win) begin
                  state     <= IDLE;
                  grant     <= '0;
                  rnd_valid <= 1'b0;
                  if (ack_win) begin
                     lfsr <= lfsr_step(lfsr);
                     ptr  <= ptr_inc;
                  end
`ifdef RNG_RESEED_EN
                  // A seed arriving on the exit edge is the newest one.
                  if (seed_we)
                     lfsr <= nonzero(seed_data);
                  else if (seed_pending)
                     lfsr <= nonzero(seed_pend_val);
                  seed_pending <= 1'b0;
`endif
               end else begin
`ifdef RNG_RESEED_EN
                  if (seed_we) begin
                     seed_pend_val <= seed_data;
                     seed_pending  <= 1'b1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
